// File: rtl/regbank_pkg.sv
// Register bank shared definitions: geometry, address/data types, ring helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regbank_pkg;

    localparam int NUMREGS   = 32;
    localparam int DATAWIDTH = 32;
    // One extra address bit beyond what NUMREGS needs, matching the bank's port.
    localparam int ADDRW     = $clog2(NUMREGS) + 1;

    typedef logic [ADDRW-1:0]     regaddr_t;
    typedef logic [DATAWIDTH-1:0] regdata_t;

    // Wrap an index that is known to lie in [0, 2n-2] back into [0, n-1].
    function automatic int rr_wrap(input int a, input int n);
        return (a >= n) ? (a - n) : a;
    endfunction

endpackage

// File: rtl/regbank_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
// Latency: purely combinational, no state.
// Backpressure: en=0 forces an all-zero grant.
// Ports: req (request vector), en (grant enable), ptr (search start index),
//        gnt (one-hot grant), gnt_idx (binary index of the grant, 0 if none).
module rr_arbiter
    import regbank_pkg::*;
#(
    parameter  int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic          found;
    logic [IW-1:0] idx;

    // Walk the ring starting at ptr; the first set request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'(rr_wrap(int'(ptr) + k, N));
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Round-robin share of the register bank write port among NUMREQ writeback units.
// Latency: 1 cycle from accept (valid & ready) to we_o/waddr_o/wdata_o.
// Backpressure: stall_i or rst_i withholds every ready; unaccepted requests just wait.
// Ports: clk_i, rst_i (sync, active-high), stall_i, req_valid_i/req_ready_o (per requester),
//        req_addr_i/req_data_i (per requester), we_o/waddr_o/wdata_o (bank write port), busy_o.
module regbank_wb_arbiter #(
    parameter  int NUMREQ       = 3,
    parameter  int NUMREGS      = regbank_pkg::NUMREGS,
    parameter  int DATAWIDTH    = regbank_pkg::DATAWIDTH,
    parameter  bit ZERO_DISCARD = 1'b1,
    localparam int ADDRW        = $clog2(NUMREGS) + 1,
    localparam int IW           = $clog2(NUMREQ)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             stall_i,
    input  logic [NUMREQ-1:0]                req_valid_i,
    output logic [NUMREQ-1:0]                req_ready_o,
    input  logic [NUMREQ-1:0][ADDRW-1:0]     req_addr_i,
    input  logic [NUMREQ-1:0][DATAWIDTH-1:0] req_data_i,
    output logic                             we_o,
    output logic [ADDRW-1:0]                 waddr_o,
    output logic [DATAWIDTH-1:0]             wdata_o,
    output logic                             busy_o
);

    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        gnt_idx;
    logic [NUMREQ-1:0]    gnt;
    logic                 accept;
    logic                 discard;
    logic [ADDRW-1:0]     sel_addr;
    logic [DATAWIDTH-1:0] sel_data;

    // Reset is folded into the enable so ready is low in every reset cycle,
    // not only after the first reset edge.
    rr_arbiter #(.N(NUMREQ)) u_arb (
        .req     (req_valid_i),
        .en      (!stall_i && !rst_i),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready_o = gnt;
    assign accept      = |gnt;
    assign sel_addr    = req_addr_i[gnt_idx];
    assign sel_data    = req_data_i[gnt_idx];

    // Register 0 is hardwired; the write is consumed (pointer advances) but
    // never reaches the bank.
    assign discard     = ZERO_DISCARD && (sel_addr == '0);

    assign busy_o      = (|req_valid_i) || we_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_o    <= 1'b0;
            waddr_o <= '0;
            wdata_o <= '0;
            rr_ptr  <= '0;
        end else if (accept) begin
            we_o    <= !discard;
            waddr_o <= sel_addr;
            wdata_o <= sel_data;
            rr_ptr  <= IW'(regbank_pkg::rr_wrap(int'(gnt_idx) + 1, NUMREQ));
        end else begin
            we_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
module tb_regbank_wb_arbiter;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             stall_i;
    logic [2:0]       req_valid_i;
    logic [2:0]       req_ready_o;
    logic [2:0][5:0]  req_addr_i;
    logic [2:0][31:0] req_data_i;
    logic             we_o;
    logic [5:0]       waddr_o;
    logic [31:0]      wdata_o;
    logic             busy_o;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [31:0] bank [64];

    regbank_wb_arbiter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (stall_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .we_o        (we_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural bank: written on the edge after we_o, unless reset wins that edge.
    always @(posedge clk_i) begin
        if (!rst_i && we_o) bank[waddr_o] <= wdata_o;
    end

    typedef struct {
        logic             rst;
        logic             stall;
        logic [2:0]       valid;
        logic [2:0][5:0]  addr;
        logic [2:0][31:0] data;
        logic [2:0]       rdy;
        logic             we;
        logic [5:0]       waddr;
        logic [31:0]      wdata;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input logic rst, input logic stall, input logic [2:0] valid,
                                input int a0, input int a1, input int a2,
                                input logic [2:0] rdy, input logic we,
                                input int waddr, input logic [31:0] wdata);
        vec_t v;
        v.rst   = rst;
        v.stall = stall;
        v.valid = valid;
        v.addr[0] = 6'(a0);
        v.addr[1] = 6'(a1);
        v.addr[2] = 6'(a2);
        // Requester i sends data (i+1)<<28 | addr so every write is traceable.
        for (int i = 0; i < 3; i++) v.data[i] = (32'(i + 1) << 28) | 32'(v.addr[i]);
        v.rdy   = rdy;
        v.we    = we;
        v.waddr = 6'(waddr);
        v.wdata = wdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    initial begin
        for (int k = 0; k < 64; k++) bank[k] = 32'hFFFF_0000 | 32'(k);

        // Reset held two cycles with every requester valid.
        vecs[0]  = mk(1, 0, 3'b111, 5, 6, 7, 3'b000, 0, 0, 32'h0);
        vecs[1]  = mk(1, 0, 3'b111, 5, 6, 7, 3'b000, 0, 0, 32'h0);
        // Round robin over all three, two full laps.
        vecs[2]  = mk(0, 0, 3'b111, 5, 6, 7, 3'b001, 1, 5, 32'h1000_0005);
        vecs[3]  = mk(0, 0, 3'b111, 5, 6, 7, 3'b010, 1, 6, 32'h2000_0006);
        vecs[4]  = mk(0, 0, 3'b111, 5, 6, 7, 3'b100, 1, 7, 32'h3000_0007);
        vecs[5]  = mk(0, 0, 3'b111, 5, 6, 7, 3'b001, 1, 5, 32'h1000_0005);
        vecs[6]  = mk(0, 0, 3'b111, 5, 6, 7, 3'b010, 1, 6, 32'h2000_0006);
        vecs[7]  = mk(0, 0, 3'b111, 5, 6, 7, 3'b100, 1, 7, 32'h3000_0007);
        // Stall for three cycles, then release.
        vecs[8]  = mk(0, 1, 3'b010, 5, 6, 7, 3'b000, 0, 0, 32'h0);
        vecs[9]  = mk(0, 1, 3'b010, 5, 6, 7, 3'b000, 0, 0, 32'h0);
        vecs[10] = mk(0, 1, 3'b010, 5, 6, 7, 3'b000, 0, 0, 32'h0);
        vecs[11] = mk(0, 0, 3'b010, 5, 6, 7, 3'b010, 1, 6, 32'h2000_0006);
        // Pointer now 2; req0 alone moves it to 1, then req1 writes address 0.
        vecs[12] = mk(0, 0, 3'b001, 5, 6, 7, 3'b001, 1, 5, 32'h1000_0005);
        vecs[13] = mk(0, 0, 3'b110, 5, 0, 7, 3'b010, 0, 0, 32'h0);
        vecs[13].data[1] = 32'hDEAD_BEEF;
        vecs[14] = mk(0, 0, 3'b110, 5, 0, 7, 3'b100, 1, 7, 32'h3000_0007);
        // Accept req2 to address 9, then reset lands on the following edge.
        vecs[15] = mk(0, 0, 3'b100, 5, 6, 9, 3'b100, 1, 9, 32'h3000_0009);
        vecs[16] = mk(1, 0, 3'b100, 5, 6, 9, 3'b000, 0, 0, 32'h0);
        // Wrap: move pointer to 2, then valid=011 grants req0 before req1.
        vecs[17] = mk(0, 0, 3'b010, 5, 6, 7, 3'b010, 1, 6, 32'h2000_0006);
        vecs[18] = mk(0, 0, 3'b011, 5, 6, 7, 3'b001, 1, 5, 32'h1000_0005);
        vecs[19] = mk(0, 0, 3'b011, 5, 6, 7, 3'b010, 1, 6, 32'h2000_0006);
        vecs[20] = mk(0, 0, 3'b000, 5, 6, 7, 3'b000, 0, 0, 32'h0);

        rst_i       = 1'b1;
        stall_i     = 1'b0;
        req_valid_i = '0;
        req_addr_i  = '0;
        req_data_i  = '0;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk_i);
            rst_i       = vecs[i].rst;
            stall_i     = vecs[i].stall;
            req_valid_i = vecs[i].valid;
            req_addr_i  = vecs[i].addr;
            req_data_i  = vecs[i].data;
            #1;
            check($sformatf("v%0d ready", i), 32'(req_ready_o), 32'(vecs[i].rdy));
            @(posedge clk_i);
            #1;
            check($sformatf("v%0d we", i), 32'(we_o), 32'(vecs[i].we));
            if (vecs[i].we) begin
                check($sformatf("v%0d waddr", i), 32'(waddr_o), 32'(vecs[i].waddr));
                check($sformatf("v%0d wdata", i), wdata_o, vecs[i].wdata);
            end
        end

        // Busy: idle after the last vector, then a lone valid raises it.
        @(negedge clk_i);
        check("busy idle", 32'(busy_o), 32'd0);
        req_valid_i = 3'b001;
        #1;
        check("busy valid", 32'(busy_o), 32'd1);
        check("ready lone req0", 32'(req_ready_o), 32'b001);
        req_valid_i = 3'b000;
        @(posedge clk_i);
        #1;
        check("busy we only", 32'(busy_o), 32'd0);

        // Bank effects: the reset-dropped write to 9 never landed; 7 holds req2's last data.
        check("bank9 unchanged", bank[9], 32'hFFFF_0009);
        check("bank7 written", bank[7], 32'h3000_0007);
        check("bank0 untouched", bank[0], 32'hFFFF_0000);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
